// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave core.
package spi_pkg;

  // Frame-level FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

  // Widest supported word; the bit counter is sized once for it so every
  // DATA_W in 2..32 shares the same counter width.
  localparam int MAX_DATA_W = 32;
  localparam int CNT_W      = $clog2(MAX_DATA_W + 1);

  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
  function automatic logic sample_is_rising(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input with single-cycle
// rise/fall pulses derived from the synchronised level. All flops reset
// low, so a line held low through reset produces no falling pulse.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  assign sync_d[0] = din;

  generate
    genvar gi;
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  assign dout   = sync_q[SYNC_STAGES-1];
  assign prev_d = dout;
  assign rise   = dout & ~prev_q;
  assign fall   = ~dout & prev_q;

  // Synchroniser chain plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/spi_slave_core.sv
// System-clocked SPI slave: oversampled SCLK/MOSI/CS_N, all four SPI modes,
// configurable word width and bit order, back-to-back words within a frame,
// valid/ready fabric interfaces and an optional echo (received+1) source.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              echo_mode,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);

  // ---------------------------------------------------------------------------
  // Bit-order helpers
  // ---------------------------------------------------------------------------
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------------
  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_sclk),
    .dout (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_cs_n),
    .dout (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // MOSI needs the same latency as SCLK so data lines up with the sample edge.
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_d;

  assign mosi_sync_d[0] = spi_mosi;

  generate
    genvar gi;
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_mosi_sync
      assign mosi_sync_d[gi] = mosi_sync_q[gi-1];
    end
  endgenerate

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // MOSI synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= mosi_sync_d;
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  spi_state_e         state_q, state_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]  tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [DATA_W-1:0]  echo_q, echo_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_overrun_q, rx_overrun_d;
  logic               tx_underrun_q, tx_underrun_d;
  logic               miso_q, miso_d;
  logic               miso_oe_q, miso_oe_d;

  logic               sample_edge, shift_edge;
  logic               in_load, word_done;
  logic [DATA_W-1:0]  rx_shift_next;
  logic [DATA_W-1:0]  tx_word;
  logic               tx_take_hold, tx_empty;

  // Pick the sample and shift edges from the mode latched at frame start.
  always_comb begin
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    if (sample_is_rising(cpol_q, cpha_q)) begin
      sample_edge = sclk_rise;
      shift_edge  = sclk_fall;
    end else begin
      sample_edge = sclk_fall;
      shift_edge  = sclk_rise;
    end
  end

  // A CS_N release wins over any load or word completion in the same cycle.
  assign in_load       = (state_q == LOAD) && !cs_rise;
  assign word_done     = (state_q == SHIFT) && !cs_rise && sample_edge &&
                         (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign rx_shift_next = shift_in(rx_shift_q, mosi_s);

  // Choose the next transmit word: echo value, holding register, or zeros.
  // At a word boundary the echo uses the word completing this cycle.
  always_comb begin
    tx_word      = '0;
    tx_take_hold = 1'b0;
    tx_empty     = 1'b0;
    if (in_load || word_done) begin
      if (echo_mode) begin
        tx_word = in_load ? echo_q : rx_shift_next + DATA_W'(1);
      end else if (hold_full_q) begin
        tx_word      = hold_q;
        tx_take_hold = 1'b1;
      end else begin
        tx_empty = 1'b1;
      end
    end
  end

  // Frame FSM, shift datapath, holding register and RX handshake.
  always_comb begin
    state_d       = state_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    echo_d        = echo_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = tx_empty;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;

    // A write can only land while empty, so it never collides with a take.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
    if (tx_take_hold) begin
      hold_full_d = 1'b0;
    end

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        if (cs_s) begin
          cpol_d = cpol;
          cpha_d = cpha;
        end
        if (cs_fall) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        bit_cnt_d  = '0;
        rx_shift_d = '0;
        miso_d     = first_bit(tx_word);
        miso_oe_d  = 1'b1;
        // With cpha=1 the first leading edge re-presents bit 0, so keep the
        // whole word in the shifter; with cpha=0 bit 0 is already on the wire.
        tx_shift_d = cpha_q ? tx_word : shift_out(tx_word);
        state_d    = SHIFT;
      end

      SHIFT: begin
        if (sample_edge) begin
          rx_shift_d = rx_shift_next;
          if (word_done) begin
            bit_cnt_d  = '0;
            echo_d     = rx_shift_next + DATA_W'(1);
            tx_shift_d = tx_word;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = rx_shift_next;
              rx_valid_d = 1'b1;
            end else begin
              rx_overrun_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        if (shift_edge) begin
          miso_d     = first_bit(tx_shift_q);
          tx_shift_d = shift_out(tx_shift_q);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (cs_rise) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end
  end

  // State register for the whole core.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      echo_q        <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      echo_q        <= echo_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = (state_q != IDLE);

  // The synchronised SCLK level itself is only consumed through its edges.
  logic unused_sclk_level;
  assign unused_sclk_level = sclk_s;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: three instances (8-bit MSB-first,
// 8-bit LSB-first, 16-bit MSB-first) share SCLK/MOSI, each has its own CS_N.
module tb_spi_slave_core;

  localparam int HALF = 8;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cpol, cpha, echo_mode, sclk, mosi;
  logic cs_a, cs_b, cs_c;

  logic [7:0]  tx_data_a, rx_data_a, tx_data_b, rx_data_b;
  logic [15:0] tx_data_c, rx_data_c;
  logic tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a, rx_overrun_a, tx_underrun_a, busy_a, miso_a, miso_oe_a;
  logic tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b, rx_overrun_b, tx_underrun_b, busy_b, miso_b, miso_oe_b;
  logic tx_valid_c, tx_ready_c, rx_valid_c, rx_ready_c, rx_overrun_c, tx_underrun_c, busy_c, miso_c, miso_oe_c;

  spi_slave_core #(.DATA_W(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .echo_mode(echo_mode),
    .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_a),
    .spi_miso(miso_a), .spi_miso_oe(miso_oe_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .rx_overrun(rx_overrun_a), .tx_underrun(tx_underrun_a), .busy(busy_a)
  );

  spi_slave_core #(.DATA_W(8), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .echo_mode(echo_mode),
    .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_b),
    .spi_miso(miso_b), .spi_miso_oe(miso_oe_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .rx_overrun(rx_overrun_b), .tx_underrun(tx_underrun_b), .busy(busy_b)
  );

  spi_slave_core #(.DATA_W(16), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_dut_c (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .echo_mode(echo_mode),
    .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_c),
    .spi_miso(miso_c), .spi_miso_oe(miso_oe_c),
    .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c),
    .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_ready(rx_ready_c),
    .rx_overrun(rx_overrun_c), .tx_underrun(tx_underrun_c), .busy(busy_c)
  );

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  int ovr_a = 0, und_a = 0, ovr_b = 0, und_b = 0, ovr_c = 0, und_c = 0;

  logic cur_miso;
  assign cur_miso = (sel == 0) ? miso_a : ((sel == 1) ? miso_b : miso_c);

  // Pulse counters for the one-cycle status outputs.
  always @(posedge clk) begin
    if (rx_overrun_a)  ovr_a <= ovr_a + 1;
    if (tx_underrun_a) und_a <= und_a + 1;
    if (rx_overrun_b)  ovr_b <= ovr_b + 1;
    if (tx_underrun_b) und_b <= und_b + 1;
    if (rx_overrun_c)  ovr_c <= ovr_c + 1;
    if (tx_underrun_c) und_c <= und_c + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=0x%0h", tag, got);
    end
  endtask

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_low();
    if (sel == 0) cs_a = 1'b0;
    else if (sel == 1) cs_b = 1'b0;
    else cs_c = 1'b0;
    half_wait();
  endtask

  task automatic cs_high();
    half_wait();
    cs_a = 1'b1;
    cs_b = 1'b1;
    cs_c = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Master side of one word: drives MOSI, samples MISO at the sample edge.
  task automatic xfer(input int nbits, input bit msb, input logic [31:0] wout,
                      output logic [31:0] win);
    int idx;
    win = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? (nbits - 1 - i) : i;
      if (!cpha) begin
        mosi = wout[idx];
        half_wait();
        sclk = ~cpol;
        win[idx] = cur_miso;
        half_wait();
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = wout[idx];
        half_wait();
        sclk = cpol;
        win[idx] = cur_miso;
        half_wait();
      end
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    tx_data_a = d; tx_valid_a = 1'b1; @(negedge clk); tx_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    tx_data_b = d; tx_valid_b = 1'b1; @(negedge clk); tx_valid_b = 1'b0;
  endtask

  task automatic push_c(input logic [15:0] d);
    tx_data_c = d; tx_valid_c = 1'b1; @(negedge clk); tx_valid_c = 1'b0;
  endtask

  task automatic ack_all();
    rx_ready_a = 1'b1; rx_ready_b = 1'b1; rx_ready_c = 1'b1;
    @(negedge clk);
    rx_ready_a = 1'b0; rx_ready_b = 1'b0; rx_ready_c = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    logic [31:0] w0, w1, w2, w3;
    int o0, u0;
    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; echo_mode = 1'b0; sclk = 1'b0; mosi = 1'b0;
    cs_a = 1'b1; cs_b = 1'b1; cs_c = 1'b1;
    tx_data_a = '0; tx_data_b = '0; tx_data_c = '0;
    tx_valid_a = 1'b0; tx_valid_b = 1'b0; tx_valid_c = 1'b0;
    rx_ready_a = 1'b0; rx_ready_b = 1'b0; rx_ready_c = 1'b0;
    do_reset();

    // Reset state
    check("rst tx_ready", 32'(tx_ready_a), 32'd1);
    check("rst rx_valid", 32'(rx_valid_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst miso_oe", 32'(miso_oe_a), 32'd0);
    check("rst miso", 32'(miso_a), 32'd0);
    check("rst rx_data", 32'(rx_data_a), 32'd0);
    check("rst pulses", 32'(ovr_a + und_a), 32'd0);

    // Mode 0, preloaded 0xA5, master sends 0x3C
    sel = 0;
    push_a(8'hA5);
    check("t1 tx_ready after write", 32'(tx_ready_a), 32'd0);
    cs_low();
    check("t1 busy in frame", 32'(busy_a), 32'd1);
    check("t1 miso_oe in frame", 32'(miso_oe_a), 32'd1);
    xfer(8, 1'b1, 32'h3C, w0);
    cs_high();
    check("t1 miso word", w0, 32'hA5);
    check("t1 rx_data", 32'(rx_data_a), 32'h3C);
    check("t1 rx_valid", 32'(rx_valid_a), 32'd1);
    check("t1 tx_ready after load", 32'(tx_ready_a), 32'd1);
    check("t1 busy after frame", 32'(busy_a), 32'd0);
    check("t1 miso_oe after frame", 32'(miso_oe_a), 32'd0);
    repeat (10) @(negedge clk);
    check("t1 rx_valid held", 32'(rx_valid_a), 32'd1);
    ack_all();
    check("t1 rx_valid cleared", 32'(rx_valid_a), 32'd0);

    // Modes 1..3, LSB first, master sends 0x01, slave sends 0x80
    sel = 1;
    for (int m = 1; m <= 3; m++) begin
      cpol = m[1];
      cpha = m[0];
      sclk = cpol;
      repeat (6) @(negedge clk);
      push_b(8'h80);
      check($sformatf("t2 mode%0d tx_ready", m), 32'(tx_ready_b), 32'd0);
      cs_low();
      xfer(8, 1'b0, 32'h01, w0);
      cs_high();
      check($sformatf("t2 mode%0d miso", m), w0, 32'h80);
      check($sformatf("t2 mode%0d rx_data", m), 32'(rx_data_b), 32'h01);
      check($sformatf("t2 mode%0d rx_valid", m), 32'(rx_valid_b), 32'd1);
      check($sformatf("t2 mode%0d busy", m), 32'(busy_b), 32'd0);
      ack_all();
    end
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    repeat (6) @(negedge clk);
    check("t2 miso_oe idle", 32'(miso_oe_b), 32'd0);

    // Echo mode, three words in one frame, then wrap to zero in the next frame
    do_reset();
    sel = 0;
    echo_mode = 1'b1;
    rx_ready_a = 1'b1;
    o0 = ovr_a;
    cs_low();
    xfer(8, 1'b1, 32'h10, w0);
    xfer(8, 1'b1, 32'h20, w1);
    xfer(8, 1'b1, 32'hFF, w2);
    cs_high();
    check("t3 echo word0", w0, 32'h00);
    check("t3 echo word1", w1, 32'h11);
    check("t3 echo word2", w2, 32'h21);
    check("t3 rx_data", 32'(rx_data_a), 32'hFF);
    cs_low();
    xfer(8, 1'b1, 32'h00, w3);
    cs_high();
    check("t3 echo wrap", w3, 32'h00);
    check("t3 no overrun", 32'(ovr_a - o0), 32'd0);
    echo_mode = 1'b0;
    repeat (4) @(negedge clk);
    rx_ready_a = 1'b0;

    // Overrun and underrun
    o0 = ovr_a;
    u0 = und_a;
    push_a(8'hC3);
    cs_low();
    xfer(8, 1'b1, 32'h55, w0);
    check("t4 underrun at word2 load", 32'(und_a - u0), 32'd1);
    xfer(8, 1'b1, 32'hAA, w1);
    cs_high();
    check("t4 miso word1", w0, 32'hC3);
    check("t4 miso word2 zeros", w1, 32'h00);
    check("t4 rx_data kept", 32'(rx_data_a), 32'h55);
    check("t4 rx_valid", 32'(rx_valid_a), 32'd1);
    check("t4 overrun pulses", 32'(ovr_a - o0), 32'd1);
    ack_all();

    // Partial word discarded, then a full word
    o0 = ovr_a;
    cs_low();
    xfer(5, 1'b1, 32'h1F, w0);
    cs_high();
    check("t5 partial rx_valid", 32'(rx_valid_a), 32'd0);
    check("t5 partial overrun", 32'(ovr_a - o0), 32'd0);
    check("t5 partial busy", 32'(busy_a), 32'd0);
    cs_low();
    xfer(8, 1'b1, 32'h77, w0);
    cs_high();
    check("t5 rx_data", 32'(rx_data_a), 32'h77);
    check("t5 rx_valid", 32'(rx_valid_a), 32'd1);
    ack_all();

    // Reset mid-word on the 16-bit instance with CS_N held low
    sel = 2;
    cs_low();
    xfer(6, 1'b1, 32'h2B, w0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t6 rst busy", 32'(busy_c), 32'd0);
    check("t6 rst miso_oe", 32'(miso_oe_c), 32'd0);
    check("t6 rst miso", 32'(miso_c), 32'd0);
    check("t6 rst tx_ready", 32'(tx_ready_c), 32'd1);
    check("t6 rst rx_valid", 32'(rx_valid_c), 32'd0);
    check("t6 rst rx_data", 32'(rx_data_c), 32'd0);
    check("t6 rst rx_valid other", 32'(rx_valid_a), 32'd0);
    xfer(16, 1'b1, 32'h1357, w0);
    check("t6 no capture before cs toggle", 32'(rx_valid_c), 32'd0);
    check("t6 idle before cs toggle", 32'(busy_c), 32'd0);
    cs_high();
    push_c(16'h1234);
    cs_low();
    xfer(16, 1'b1, 32'hBEEF, w0);
    cs_high();
    check("t6 miso word16", w0, 32'h1234);
    check("t6 rx_data16", 32'(rx_data_c), 32'hBEEF);
    check("t6 rx_valid16", 32'(rx_valid_c), 32'd1);
    ack_all();

    // Pulse totals for the secondary instances
    check("end overrun b", 32'(ovr_b), 32'd0);
    check("end underrun b", 32'(und_b), 32'd3);
    check("end overrun c", 32'(ovr_c), 32'd0);
    check("end underrun c", 32'(und_c), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
Parametrised, fully synchronous SPI slave. It replaces the SCLK-clocked behavioural slave model with a system-clock design. SCLK, MOSI and CS_N are oversampled through synchronisers. All four SPI modes are supported, word width is configurable, and consecutive words can be sent within one CS frame. It sits behind the spi_master bench as a DUT-grade peer and has valid/ready data interfaces on the fabric side.

Parameters:
DATA_W, 8, word width in bits (2..32)
MSB_FIRST, 1, 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first
SYNC_STAGES, 2, synchroniser depth on spi_sclk/spi_mosi/spi_cs_n (≥2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpol  in  1  clock polarity; sampled only while synced CS_N is high
cpha  in  1  clock phase; sampled only while synced CS_N is high
echo_mode  in  1  1 = each transmitted word is the previous received word +1; tx_* ignored
spi_sclk  in  1  SPI clock (async)
spi_mosi  in  1  SPI data in (async)
spi_cs_n  in  1  chip select, active low (async)
spi_miso  out  1  SPI data out
spi_miso_oe  out  1  MISO output enable (high while frame active)
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty
rx_data  out  DATA_W  last received word
rx_valid  out  1  rx_data valid, held until accepted
rx_ready  in  1  consumer accepts rx_data
rx_overrun  out  1  one-cycle pulse: word dropped because rx_valid was still set
tx_underrun  out  1  one-cycle pulse: word started with empty holding register
busy  out  1  frame active (FSM not IDLE)

Behaviour:
- Reset: all outputs 0 except tx_ready=1; FSM=IDLE; counters, shift registers, holding register and latched mode cleared; echo register=0.
- Sync and edge detection:
  - Inputs pass through SYNC_STAGES flops; edges are detected on the synced SCLK vs its previous value.
  - Leading edge = rising if cpol=0, falling if cpol=1. Sample edge = leading if cpha=0, trailing if cpha=1; the other edge is the shift edge.
- Timing constraint: SCLK high and low phases each ≥ SYNC_STAGES+2 clk cycles. Behaviour above this rate is undefined.
- FSM states IDLE, LOAD, SHIFT:
  - IDLE: latch cpol/cpha every cycle; miso_oe=0, miso=0. Synced CS_N falling → LOAD.
  - LOAD (1 cycle): TX shift register is loaded (see TX source); bit_cnt=0; first bit driven on miso; miso_oe=1 → SHIFT.
  - SHIFT: on each sample edge, shift the synced MOSI into the RX shift register and increment bit_cnt. On each shift edge, present the next TX bit. For cpha=1, the first leading edge presents bit 0 (no shift).
  - SHIFT, on the sample edge where bit_cnt reaches DATA_W:
    - If rx_valid=0: rx_data ← RX shift register, rx_valid=1 next cycle.
    - If rx_valid=1: word dropped, rx_overrun pulses, rx_data unchanged.
    - bit_cnt wraps to 0; the TX shift register reloads on the same cycle for back-to-back words. The first bit of the new word appears at the next shift edge for cpha=0, or the next leading edge for cpha=1.
  - Synced CS_N rising in any state → IDLE next cycle. A partial word is discarded: no rx_valid, no overrun. An unconsumed holding word is retained.
- TX source at each load:
  - echo_mode=1: last received word +1, mod 2^DATA_W (0 for the first word after reset).
  - Otherwise, holding register if full (then tx_ready←1).
  - Otherwise, all zeros with tx_underrun pulsed.
- Holding register: written when tx_valid && tx_ready (tx_ready←0 next cycle). A write in the same cycle as a load goes into the holding register for the following word.
- RX handshake: rx_valid clears on rx_valid && rx_ready. Simultaneous clear and new word completion → new word captured, rx_valid stays 1, no overrun.
- cpol/cpha changes while busy=1 are ignored.
- Reset asserted mid-frame → reset state. A new frame starts only after CS_N is seen high then low again.

Decomposition:
- Package spi_pkg: typedef spi_state_e {IDLE, LOAD, SHIFT}; function sample_is_rising(cpol, cpha); localparam CNT_W = $clog2(DATA_W+1).
- Sub-module spi_sync_edge (parametrised SYNC_STAGES): synchroniser plus rise/fall pulse outputs; instantiated for SCLK and CS_N. MOSI uses the synchroniser only.

Test Plan:
- Mode 0, DATA_W=8, tx_data=0xA5 preloaded, master sends 0x3C → MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1 until rx_ready.
- All modes 1/2/3, MSB_FIRST=0, master sends 0x01 with tx 0x80 → rx_data=0x01 and master receives 0x80 in each mode.
- echo_mode=1, single frame of 3 words 0x10,0x20,0xFF → MISO words 0x00,0x11,0x21; next frame's first word 0x00 (0xFF+1 wraps).
- rx_ready held low, two words 0x55,0xAA → rx_data=0x55, one rx_overrun pulse; empty holding on word 2 → tx_underrun pulse, MISO all zeros.
- CS_N deasserted after 5 bits, then full word 0x77 → no rx_valid for the partial word; rx_data=0x77 afterwards.
- rst pulsed mid-word with CS_N still low → all outputs at reset values; no capture until CS_N toggles high→low; DATA_W=16 rerun with 0xBEEF passes.
